div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 24 ++
 rtl/div_unit_if.sv | 25 ++
 rtl/div_unit_step.sv | 23 ++
 rtl/div_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared types and constants for the 32-bit restoring divider.
// Holds the state encodings, result-ready and stall levels, and the negate helper.
package div_unit_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ITER_N = 32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic STOP                 = 1'b1;
  localparam logic NO_STOP              = 1'b0;

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// EX-side handshake bundle of the divider.
// The master modport belongs to EX; the slave modport belongs to the divider.
interface div_unit_if;
  import div_unit_pkg::*;

  logic                start_i;
  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                annul_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;
  logic                stallreq_for_ex;

  modport master (
    output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stallreq_for_ex
  );

  modport slave (
    input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stallreq_for_ex
  );

endinterface

// File: rtl/div_unit_step.sv
// One restoring shift-subtract iteration on the 65-bit working register.
// Layout: [64:33] remainder, [32:1] unconsumed dividend / quotient bits, [0] newest quotient bit.
module div_step
  import div_unit_pkg::*;
(
  input  logic [2*DATA_W:0]   part_i,
  input  logic [DATA_W-1:0]   divisor_i,
  output logic [2*DATA_W:0]   part_o
);

  logic              ge;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] rem;

  always_comb begin
    // Compare the 33-bit partial remainder; the difference always fits in 32 bits.
    ge     = (part_i[2*DATA_W:DATA_W] >= {1'b0, divisor_i});
    diff   = part_i[2*DATA_W-1:DATA_W] - divisor_i;
    rem    = ge ? diff : part_i[2*DATA_W-1:DATA_W];
    part_o = {rem, part_i[DATA_W-1:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider for the EX stage.
// result_o = {remainder, quotient}; stalls EX until ready_o.
//
// state       | meaning
// DIV_FREE    | idle, waiting for start_i
// DIV_BY_ZERO | divisor was zero, zero result on the next edge
// DIV_ON      | 32 iterations, then sign correction
// DIV_END     | result held while start_i stays high
module div_unit
  import div_unit_pkg::*;
(
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  div_state_e          state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2*DATA_W:0]   part_q, part_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;

  logic [2*DATA_W:0]   step_part;
  logic [DATA_W-1:0]   op1_mag;
  logic [DATA_W-1:0]   op2_mag;

  div_step u_step (
    .part_i    (part_q),
    .divisor_i (divisor_q),
    .part_o    (step_part)
  );

  assign op1_mag = neg_if(bus.opdata1_i, bus.signed_div_i & bus.opdata1_i[DATA_W-1]);
  assign op2_mag = neg_if(bus.opdata2_i, bus.signed_div_i & bus.opdata2_i[DATA_W-1]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    part_d    = part_q;
    divisor_d = divisor_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d   = DIV_ON;
            cnt_d     = '0;
            part_d    = {{DATA_W{1'b0}}, op1_mag, 1'b0};
            divisor_d = op2_mag;
            qneg_d    = bus.signed_div_i & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
            rneg_d    = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
          end
        end
      end

      DIV_BY_ZERO: begin
        if (bus.annul_i) begin
          state_d = DIV_FREE;
        end else begin
          state_d  = DIV_END;
          result_d = '0;
          ready_d  = DIV_RESULT_READY;
        end
      end

      DIV_ON: begin
        if (bus.annul_i) begin
          state_d = DIV_FREE;
          cnt_d   = '0;
        end else if (cnt_q != 6'(ITER_N)) begin
          part_d = step_part;
          cnt_d  = cnt_q + 6'd1;
        end else begin
          state_d  = DIV_END;
          result_d = {neg_if(part_q[2*DATA_W:DATA_W+1], rneg_q),
                      neg_if(part_q[DATA_W-1:0], qneg_q)};
          ready_d  = DIV_RESULT_READY;
        end
      end

      DIV_END: begin
        if (!bus.start_i || bus.annul_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end

      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      part_q    <= '0;
      divisor_q <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      part_q    <= part_d;
      divisor_q <= divisor_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o        = result_q;
  assign bus.ready_o         = ready_q;
  assign bus.stallreq_for_ex = (bus.start_i & ~ready_q & ~bus.annul_i & ~rst) ? STOP : NO_STOP;

endmodule
